// File: rtl/fitness_pkg.sv
// Shared definitions for the workout calculator, session timer and display stages.
// Phase encoding is visible on the timer's phase port and decoded downstream.
package fitness_pkg;

  localparam int PHASE_W = 2;

  localparam logic [PHASE_W-1:0] PH_IDLE = 2'd0;
  localparam logic [PHASE_W-1:0] PH_WORK = 2'd1;
  localparam logic [PHASE_W-1:0] PH_REST = 2'd2;
  localparam logic [PHASE_W-1:0] PH_DONE = 2'd3;

  localparam int SECS_PER_MIN = 60;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle tick per second of enabled time.
// The count holds while en is low, so a paused phase resumes mid-second.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/workout_session_timer.sv
// Splits a total-minutes figure into capped work sessions separated by fixed rests,
// counting each phase down as mm:ss with pause, abort and a completion pulse.
module workout_session_timer
  import fitness_pkg::*;
#(
  parameter int TICKS_PER_SEC   = 50_000_000,
  parameter int MAX_SESSION_MIN = 30,
  parameter int REST_SEC        = 45
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes_in,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [1:0] phase,
  output logic       busy,
  output logic [7:0] mins_left,
  output logic [5:0] secs_left,
  output logic [3:0] session_idx,
  output logic       last_session,
  output logic       done
);

  localparam logic [7:0] MAX_SESS  = 8'(MAX_SESSION_MIN);
  localparam logic [5:0] REST_S    = 6'(REST_SEC);
  localparam logic [5:0] SEC_WRAP  = 6'(SECS_PER_MIN - 1);

  logic [1:0] state_q;
  logic [7:0] mins_q;
  logic [5:0] secs_q;
  logic [3:0] idx_q;
  logic [7:0] rem_q;
  logic       done_q;

  logic       active;
  logic       tick;
  logic       at_zero;
  logic [7:0] first_sess;
  logic [7:0] next_sess;

  // Session length is the pool clamped to the cap; one compare, no divide.
  function automatic logic [7:0] clamp_session(input logic [7:0] pool);
    return (pool > MAX_SESS) ? MAX_SESS : pool;
  endfunction

  assign active     = (state_q == PH_WORK) || (state_q == PH_REST);
  assign first_sess = clamp_session(minutes_in);
  assign next_sess  = clamp_session(rem_q);
  assign at_zero    = tick && (mins_q == 8'd0) && (secs_q == 6'd1);

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (active && !pause),
    .clr  (!active || abort),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_IDLE;
      mins_q  <= '0;
      secs_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= PH_IDLE;
        mins_q  <= '0;
        secs_q  <= '0;
        idx_q   <= '0;
        rem_q   <= '0;
      end else begin
        case (state_q)
          PH_IDLE: begin
            if (start && (minutes_in != 8'd0)) begin
              state_q <= PH_WORK;
              mins_q  <= first_sess;
              secs_q  <= '0;
              idx_q   <= '0;
              rem_q   <= minutes_in - first_sess;
            end
          end
          PH_WORK, PH_REST: begin
            if (tick) begin
              if (!at_zero) begin
                if (secs_q == 6'd0) begin
                  mins_q <= mins_q - 8'd1;
                  secs_q <= SEC_WRAP;
                end else begin
                  secs_q <= secs_q - 6'd1;
                end
              // 0:00 is never shown: the phase change replaces it on the same edge.
              end else if (state_q == PH_REST) begin
                state_q <= PH_WORK;
                mins_q  <= next_sess;
                secs_q  <= '0;
                idx_q   <= idx_q + 4'd1;
                rem_q   <= rem_q - next_sess;
              end else if (rem_q != 8'd0) begin
                state_q <= PH_REST;
                mins_q  <= '0;
                secs_q  <= REST_S;
              end else begin
                state_q <= PH_DONE;
                mins_q  <= '0;
                secs_q  <= '0;
                idx_q   <= '0;
                done_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= PH_IDLE;
          end
        endcase
      end
    end
  end

  assign phase        = state_q;
  assign busy         = active;
  assign mins_left    = mins_q;
  assign secs_left    = secs_q;
  assign session_idx  = idx_q;
  assign last_session = (state_q == PH_WORK) && (rem_q == 8'd0);
  assign done         = done_q;

endmodule

// File: tb/tb_workout_session_timer.sv
// Directed scenarios for workout_session_timer with a cycle-stamped expectation queue.
module tb_workout_session_timer;

  localparam int TPS  = 4;
  localparam int MAXS = 30;
  localparam int RSTS = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] minutes_in;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] phase;
  logic       busy;
  logic [7:0] mins_left;
  logic [5:0] secs_left;
  logic [3:0] session_idx;
  logic       last_session;
  logic       done;

  workout_session_timer #(
    .TICKS_PER_SEC  (TPS),
    .MAX_SESSION_MIN(MAXS),
    .REST_SEC       (RSTS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .minutes_in  (minutes_in),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .phase       (phase),
    .busy        (busy),
    .mins_left   (mins_left),
    .secs_left   (secs_left),
    .session_idx (session_idx),
    .last_session(last_session),
    .done        (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned exp_cyc_q[$];
  logic [22:0] exp_val_q[$];
  string       exp_tag_q[$];

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned t0 = 0;
  int          done_cnt = 0;
  logic        seen_rest = 1'b0;

  function automatic logic [22:0] pack_exp(logic [1:0] ph, logic [7:0] m, logic [5:0] s,
                                           logic [3:0] i, logic l, logic d);
    logic b;
    b = (ph == 2'd1) || (ph == 2'd2);
    return {ph, b, m, s, i, l, d};
  endfunction

  function automatic logic [22:0] observed();
    return {phase, busy, mins_left, secs_left, session_idx, last_session, done};
  endfunction

  task automatic check(string tag, logic [22:0] obs, logic [22:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_at(int unsigned rel, logic [1:0] ph, logic [7:0] m, logic [5:0] s,
                           logic [3:0] i, logic l, logic d, string tag);
    int pos;
    pos = exp_cyc_q.size();
    for (int k = 0; k < exp_cyc_q.size(); k++) begin
      if (exp_cyc_q[k] > rel) begin
        pos = k;
        break;
      end
    end
    exp_cyc_q.insert(pos, rel);
    exp_val_q.insert(pos, pack_exp(ph, m, s, i, l, d));
    exp_tag_q.insert(pos, tag);
  endtask

  task automatic run_to(int unsigned target);
    int unsigned rel;
    do begin
      @(negedge clk);
      rel = cyc - t0;
      if (done) done_cnt++;
      if (phase == 2'd2) seen_rest = 1'b1;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] == rel) begin
        check(exp_tag_q[0], observed(), exp_val_q[0]);
        void'(exp_cyc_q.pop_front());
        void'(exp_val_q.pop_front());
        void'(exp_tag_q.pop_front());
      end
    end while (rel < target);
  endtask

  task automatic expect_drained(string tag);
    check_int(tag, exp_cyc_q.size(), 0);
    exp_cyc_q.delete();
    exp_val_q.delete();
    exp_tag_q.delete();
  endtask

  task automatic do_start(logic [7:0] m);
    @(negedge clk);
    minutes_in = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    done_cnt = 0;
    seen_rest = 1'b0;
  endtask

  task automatic reset_pulse(string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check(tag, observed(), pack_exp(2'd0, 8'd0, 6'd0, 4'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_single(string p);
    expect_at(0,    2'd1, 8'd20, 6'd0,  4'd0, 1'b1, 1'b0, {p, "_load"});
    expect_at(3,    2'd1, 8'd20, 6'd0,  4'd0, 1'b1, 1'b0, {p, "_pre_tick"});
    expect_at(4,    2'd1, 8'd19, 6'd59, 4'd0, 1'b1, 1'b0, {p, "_first_dec"});
    expect_at(2400, 2'd1, 8'd10, 6'd0,  4'd0, 1'b1, 1'b0, {p, "_half"});
    expect_at(4799, 2'd1, 8'd0,  6'd1,  4'd0, 1'b1, 1'b0, {p, "_last_sec"});
    expect_at(4800, 2'd3, 8'd0,  6'd0,  4'd0, 1'b0, 1'b1, {p, "_done"});
    expect_at(4801, 2'd0, 8'd0,  6'd0,  4'd0, 1'b0, 1'b0, {p, "_idle"});
  endtask

  initial begin
    rst_n = 1'b1;
    minutes_in = 8'd0;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    reset_pulse("reset_async");

    // Single 20-minute session, with a start attempted while busy.
    do_start(8'd20);
    push_single("single");
    expect_at(101, 2'd1, 8'd19, 6'd35, 4'd0, 1'b1, 1'b0, "busy_start_ignored");
    run_to(100);
    minutes_in = 8'd50;
    start = 1'b1;
    run_to(101);
    start = 1'b0;
    run_to(4801);
    expect_drained("single_drained");
    check_int("single_done_count", done_cnt, 1);
    check_int("single_no_rest", int'(seen_rest), 0);

    // 75 minutes: 30 + rest + 30 + rest + 15.
    do_start(8'd75);
    expect_at(0,     2'd1, 8'd30, 6'd0,  4'd0, 1'b0, 1'b0, "multi_s0_load");
    expect_at(4,     2'd1, 8'd29, 6'd59, 4'd0, 1'b0, 1'b0, "multi_s0_dec");
    expect_at(7199,  2'd1, 8'd0,  6'd1,  4'd0, 1'b0, 1'b0, "multi_s0_end");
    expect_at(7200,  2'd2, 8'd0,  6'd5,  4'd0, 1'b0, 1'b0, "multi_rest0");
    expect_at(7204,  2'd2, 8'd0,  6'd4,  4'd0, 1'b0, 1'b0, "multi_rest0_dec");
    expect_at(7219,  2'd2, 8'd0,  6'd1,  4'd0, 1'b0, 1'b0, "multi_rest0_end");
    expect_at(7220,  2'd1, 8'd30, 6'd0,  4'd1, 1'b0, 1'b0, "multi_s1_load");
    expect_at(14419, 2'd1, 8'd0,  6'd1,  4'd1, 1'b0, 1'b0, "multi_s1_end");
    expect_at(14420, 2'd2, 8'd0,  6'd5,  4'd1, 1'b0, 1'b0, "multi_rest1");
    expect_at(14440, 2'd1, 8'd15, 6'd0,  4'd2, 1'b1, 1'b0, "multi_s2_load");
    expect_at(18039, 2'd1, 8'd0,  6'd1,  4'd2, 1'b1, 1'b0, "multi_s2_end");
    expect_at(18040, 2'd3, 8'd0,  6'd0,  4'd0, 1'b0, 1'b1, "multi_done");
    expect_at(18041, 2'd0, 8'd0,  6'd0,  4'd0, 1'b0, 1'b0, "multi_idle");
    run_to(18041);
    expect_drained("multi_drained");
    check_int("multi_done_count", done_cnt, 1);

    // Abort in the middle of the first rest.
    do_start(8'd75);
    expect_at(7200, 2'd2, 8'd0, 6'd5, 4'd0, 1'b0, 1'b0, "abort_rest_entered");
    expect_at(7210, 2'd2, 8'd0, 6'd3, 4'd0, 1'b0, 1'b0, "abort_before");
    expect_at(7211, 2'd0, 8'd0, 6'd0, 4'd0, 1'b0, 1'b0, "abort_idle");
    expect_at(7240, 2'd0, 8'd0, 6'd0, 4'd0, 1'b0, 1'b0, "abort_stays_idle");
    run_to(7210);
    abort = 1'b1;
    run_to(7211);
    abort = 1'b0;
    run_to(7240);
    expect_drained("abort_drained");
    check_int("abort_no_done", done_cnt, 0);

    // Zero-minute start must be ignored.
    do_start(8'd0);
    expect_at(0,  2'd0, 8'd0, 6'd0, 4'd0, 1'b0, 1'b0, "zero_start_idle");
    expect_at(10, 2'd0, 8'd0, 6'd0, 4'd0, 1'b0, 1'b0, "zero_start_later");
    run_to(10);
    expect_drained("zero_drained");
    check_int("zero_no_done", done_cnt, 0);

    // 100 cycles of pause mid-session.
    do_start(8'd20);
    expect_at(1000, 2'd1, 8'd15, 6'd50, 4'd0, 1'b1, 1'b0, "pause_enter");
    expect_at(1004, 2'd1, 8'd15, 6'd50, 4'd0, 1'b1, 1'b0, "pause_frozen_a");
    expect_at(1050, 2'd1, 8'd15, 6'd50, 4'd0, 1'b1, 1'b0, "pause_frozen_b");
    expect_at(1100, 2'd1, 8'd15, 6'd50, 4'd0, 1'b1, 1'b0, "pause_frozen_c");
    expect_at(1103, 2'd1, 8'd15, 6'd50, 4'd0, 1'b1, 1'b0, "pause_resume_pre");
    expect_at(1104, 2'd1, 8'd15, 6'd49, 4'd0, 1'b1, 1'b0, "pause_resume_dec");
    expect_at(4899, 2'd1, 8'd0,  6'd1,  4'd0, 1'b1, 1'b0, "pause_last_sec");
    expect_at(4900, 2'd3, 8'd0,  6'd0,  4'd0, 1'b0, 1'b1, "pause_done");
    expect_at(4901, 2'd0, 8'd0,  6'd0,  4'd0, 1'b0, 1'b0, "pause_idle");
    run_to(1000);
    pause = 1'b1;
    run_to(1100);
    pause = 1'b0;
    run_to(4901);
    expect_drained("pause_drained");
    check_int("pause_done_count", done_cnt, 1);

    // Reset during work, then a clean 20-minute plan.
    do_start(8'd75);
    expect_at(500, 2'd1, 8'd27, 6'd55, 4'd0, 1'b0, 1'b0, "rstmid_work");
    run_to(500);
    expect_drained("rstmid_pre_drained");
    reset_pulse("rstmid_async");
    do_start(8'd20);
    push_single("after_rst");
    run_to(4801);
    expect_drained("after_rst_drained");
    check_int("after_rst_done_count", done_cnt, 1);
    check_int("after_rst_no_rest", int'(seen_rest), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
